// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Assembles a little-endian byte
// stream (LEN, N data words, CHK) into 32-bit words, writes them to
// instruction/data memory and verifies a trailing XOR checksum.
module imem_loader #(
    parameter int          MEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    localparam int         WW        = $clog2(MEM_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_din,
    output logic          mem_write,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [WW-1:0] words_written
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_SUM   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    localparam logic [31:0] LP_DEPTH = 32'(MEM_DEPTH);

    state_t        r_state;
    state_t        w_next_state;
    logic [1:0]    r_byte_cnt;
    logic [31:0]   r_shift;
    logic [31:0]   r_len;
    logic [31:0]   r_xor;
    logic [WW-1:0] r_words;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_din;
    logic          r_mem_write;
    logic          r_byte_ready;
    logic          r_busy;
    logic          r_done;
    logic          r_error;

    logic          w_accept;
    logic          w_last_byte;
    logic          w_start_take;
    logic [31:0]   w_assembled;
    logic [31:0]   w_words_next;
    logic [31:0]   w_word_offset;

    // A transfer happens only when the registered ready and the source's valid coincide.
    assign w_accept      = byte_valid & r_byte_ready;
    assign w_last_byte   = (r_byte_cnt == 2'd3);
    assign w_start_take  = start & ((r_state == ST_IDLE) | (r_state == ST_DONE) | (r_state == ST_ERR));
    // First byte of a word ends up in bits [7:0] after four shifts.
    assign w_assembled   = {byte_data, r_shift[31:8]};
    assign w_words_next  = {{(32-WW){1'b0}}, r_words} + 32'd1;
    assign w_word_offset = {{(32-WW-2){1'b0}}, r_words, 2'b00};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode for the load sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_next_state = ST_LEN;
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_LEN: begin
                if (w_accept && w_last_byte) begin
                    if (w_assembled > LP_DEPTH) begin
                        w_next_state = ST_ERR;
                    end else if (w_assembled == 32'd0) begin
                        w_next_state = ST_SUM;
                    end else begin
                        w_next_state = ST_DATA;
                    end
                end else begin
                    w_next_state = ST_LEN;
                end
            end
            ST_DATA: begin
                if (w_accept && w_last_byte) begin
                    w_next_state = ST_WRITE;
                end else begin
                    w_next_state = ST_DATA;
                end
            end
            ST_WRITE: begin
                if (w_words_next == r_len) begin
                    w_next_state = ST_SUM;
                end else begin
                    w_next_state = ST_DATA;
                end
            end
            ST_SUM: begin
                if (w_accept && w_last_byte) begin
                    if (w_assembled == r_xor) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_ERR;
                    end
                end else begin
                    w_next_state = ST_SUM;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; status flags follow the next state so they are valid one cycle after the deciding edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte_cnt   <= 2'd0;
            r_shift      <= 32'd0;
            r_len        <= 32'd0;
            r_xor        <= 32'd0;
            r_words      <= '0;
            r_mem_addr   <= BASE_ADDR;
            r_mem_din    <= 32'd0;
            r_mem_write  <= 1'b0;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_byte_ready <= (w_next_state == ST_LEN) | (w_next_state == ST_DATA) | (w_next_state == ST_SUM);
            r_busy       <= (w_next_state == ST_LEN) | (w_next_state == ST_DATA) |
                            (w_next_state == ST_WRITE) | (w_next_state == ST_SUM);
            r_mem_write  <= (w_next_state == ST_WRITE);
            r_done       <= (w_next_state == ST_DONE);
            r_error      <= (w_next_state == ST_ERR);
            if (w_start_take) begin
                r_byte_cnt <= 2'd0;
                r_words    <= '0;
                r_xor      <= 32'd0;
            end else begin
                if (w_accept) begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    r_shift    <= w_assembled;
                end
                if ((r_state == ST_LEN) && w_accept && w_last_byte) begin
                    r_len <= w_assembled;
                end
                if ((r_state == ST_DATA) && w_accept && w_last_byte) begin
                    r_mem_din  <= w_assembled;
                    r_mem_addr <= BASE_ADDR + w_word_offset;
                end
                if (r_state == ST_WRITE) begin
                    r_xor   <= r_xor ^ r_mem_din;
                    r_words <= r_words + {{(WW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign byte_ready    = r_byte_ready;
    assign mem_addr      = r_mem_addr;
    assign mem_din       = r_mem_din;
    assign mem_write     = r_mem_write;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign words_written = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares every mem_write strobe.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_write;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] words_written;

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];
    logic [31:0] tb_mem [0:1023];

    imem_loader #(.MEM_DEPTH(1024), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_write(mem_write),
        .busy(busy), .done(done), .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: captures on the edge that ends the write cycle.
    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_addr[11:2]] <= mem_din;
    end

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_write) begin
            logic [63:0] e;
            check("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %h data %h, none expected", mem_addr, mem_din);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", mem_addr, e[63:32]);
                check("write_data", mem_din, e[31:0]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   waited;
        bit   got;
        waited = 0;
        got = 1'b0;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (!got) begin
            rdy = byte_ready;
            @(posedge clk);
            if (rdy) begin
                got = 1'b1;
            end else begin
                waited++;
                if (waited > 100) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL byte_timeout: byte %h never accepted", b);
                    got = 1'b1;
                end
            end
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] tmp;
            tmp = w >> (8 * i);
            send_byte(tmp[7:0], gaps ? int'($urandom_range(0, 3)) : 0);
        end
    endtask

    task automatic do_start;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_ready", {31'd0, byte_ready}, 32'd1);
        check("start_done_clr", {31'd0, done}, 32'd0);
        check("start_err_clr", {31'd0, error}, 32'd0);
    endtask

    task automatic run_load(input logic [31:0] len, input int nw, input logic [31:0] w0,
                            input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] chk,
                            input bit gaps, input bit exp_done, input int exp_ww);
        logic [31:0] wds [0:2];
        wds[0] = w0; wds[1] = w1; wds[2] = w2;
        do_start();
        send_word(len, gaps);
        for (int i = 0; i < nw; i++) begin
            exp_q.push_back({32'(4 * i), wds[i]});
            send_word(wds[i], gaps);
        end
        send_word(chk, gaps);
        byte_valid = 1'b0;
        check("final_done", {31'd0, done}, {31'd0, exp_done});
        check("final_error", {31'd0, error}, {31'd0, ~exp_done});
        check("final_busy", {31'd0, busy}, 32'd0);
        check("final_ready", {31'd0, byte_ready}, 32'd0);
        check("final_words", {21'd0, words_written}, 32'(exp_ww));
        check("writes_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values;
        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_write", {31'd0, mem_write}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_din", mem_din, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_words", {21'd0, words_written}, 32'd0);
    endtask

    localparam logic [31:0] W0 = 32'hfe010113;
    localparam logic [31:0] W1 = 32'h00112e23;
    localparam logic [31:0] W2 = 32'h00812c23;
    localparam logic [31:0] CK = 32'hfe910313;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Nominal, byte_valid held high (also covers valid during WRITE).
        run_load(32'd3, 3, W0, W1, W2, CK, 1'b0, 1'b1, 3);
        // Bad checksum: writes still happen.
        run_load(32'd3, 3, W0, W1, W2, 32'h0, 1'b0, 1'b0, 3);
        // Empty loads.
        run_load(32'd0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 0);
        run_load(32'd0, 0, 32'h0, 32'h0, 32'h0, 32'h1, 1'b0, 1'b0, 0);
        // Random gaps.
        run_load(32'd3, 3, W0, W1, W2, CK, 1'b1, 1'b1, 3);

        // Overflow: LEN=1025 rejected after the 4th LEN byte.
        do_start();
        send_word(32'd1025, 1'b0);
        byte_valid = 1'b0;
        check("ovf_error", {31'd0, error}, 32'd1);
        check("ovf_done", {31'd0, done}, 32'd0);
        check("ovf_ready", {31'd0, byte_ready}, 32'd0);
        check("ovf_words", {21'd0, words_written}, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-load after two words plus two bytes of the third.
        tb_mem[0] = 32'h0;
        tb_mem[1] = 32'h0;
        do_start();
        send_word(32'd3, 1'b0);
        exp_q.push_back({32'h0, 32'h11111111});
        send_word(32'h11111111, 1'b0);
        exp_q.push_back({32'h4, 32'h22222222});
        send_word(32'h22222222, 1'b0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        reset = 1'b1;
        byte_valid = 1'b0;
        #1;
        check_reset_values();
        check("mem0_kept", tb_mem[0], 32'h11111111);
        check("mem1_kept", tb_mem[1], 32'h22222222);
        check("rst_q_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_load(32'd3, 3, W0, W1, W2, CK, 1'b0, 1'b1, 3);

        // Start while busy is ignored.
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        byte_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_start_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        exp_q.push_back({32'h0, 32'h11223344});
        send_word(32'h11223344, 1'b0);
        exp_q.push_back({32'h4, 32'ha5a5a5a5});
        send_word(32'ha5a5a5a5, 1'b0);
        send_word(32'hb48796e1, 1'b0);
        byte_valid = 1'b0;
        check("busy_start_done", {31'd0, done}, 32'd1);
        check("busy_start_words", {21'd0, words_written}, 32'd2);
        // Start from DONE: done clears (checked in do_start) and load restarts at BASE_ADDR.
        run_load(32'd2, 2, 32'hdeadbeef, 32'h01020304, 32'h0, 32'hdfafbdeb, 1'b0, 1'b1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that is the write side of the instruction-memory interface. It receives a little-endian byte stream through a valid/ready handshake and assembles 32-bit words. Each word is written sequentially into instruction or data memory through the word-addressed write port (byte address, mem_write, din). The data is verified against a trailing XOR checksum, and the CPU is held off while loading.

## Interface
- MEM_DEPTH, 1024: capacity of target memory in 32-bit words; larger lengths are rejected.
- BASE_ADDR, 32'h0: byte address of first written word; must be 4-byte aligned.
- clk  in  1  system clock, all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored while busy.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte this cycle; transfer occurs on edge where byte_valid && byte_ready.
- mem_addr  out  32  byte address of the word being written (memory drops low 2 bits).
- mem_din  out  32  word being written.
- mem_write  out  1  one-cycle write strobe.
- busy  out  1  load in progress; drives CPU hold.
- done  out  1  load finished, checksum matched; held until next start or reset.
- error  out  1  load rejected (length overflow or checksum mismatch); held until next start or reset.
- words_written  out  11  count of words written in current/last load.

## Operation
- Stream format, all fields little-endian (first byte -> bits [7:0]): LEN word (N), then N data words, then CHK word.
- States: IDLE, LEN, DATA, WRITE, SUM, DONE, ERR.
- IDLE/DONE/ERR + start -> LEN. On entry, clear the byte counter, word counter, running XOR, done and error.
- LEN: accept 4 bytes.
  - On the 4th byte: N > MEM_DEPTH -> ERR, with no writes.
  - N == 0 -> SUM.
  - Otherwise -> DATA.
- DATA: accept 4 bytes into the shift/assembly register. On the 4th byte -> WRITE.
- WRITE, exactly one cycle:
  - Outputs: mem_write=1, mem_din=assembled word, mem_addr=BASE_ADDR+4*k, where k is the word index from 0.
  - Updates: running XOR ^= word; words_written increments on exit.
  - Exit -> SUM if k+1 == N, else DATA.
- SUM: accept 4 bytes. On the 4th byte: CHK == running XOR -> DONE, else ERR.
  - Data words already written stay written; error does not roll back memory.
- byte_ready is 1 only in LEN, DATA and SUM, and 0 in all other states.
  - An offered byte is never dropped; the source holds it until accepted.
- busy is 1 in LEN, DATA, WRITE and SUM.
- LEN field is 32 bits; comparison against MEM_DEPTH is unsigned, full width.
- words_written saturates logically at MEM_DEPTH, since N ≤ MEM_DEPTH; the width is clog2(MEM_DEPTH)+1.
- mem_addr arithmetic is 32-bit, with no wrap in range because N ≤ MEM_DEPTH.

## Timing
- Reset values: state IDLE, byte_ready 0, mem_write 0, mem_addr BASE_ADDR, mem_din 0, busy 0, done 0, error 0, words_written 0.
- start sampled at edge t -> busy and byte_ready are 1 in cycle t+1.
- Write latency: 4th data byte accepted at edge t -> mem_write high during cycle t..t+1 -> memory captures at edge t+1.
  - byte_ready is 1 again from cycle after t+1.
  - Best case is 5 cycles per word.
- done/error assert the cycle after the accepting edge of the final decisive byte.
- Simultaneous start and byte_valid in IDLE: start taken; the byte is not accepted, because byte_ready=0 in IDLE.
- start while busy: no effect on any state or output.
- Reset mid-load, any state: immediate return to reset values, with no further writes.
  - Memory already written is unchanged.
  - A partial word is discarded.
- byte_valid outside LEN/DATA/SUM: ignored, not counted.

## Test plan
- Nominal: start; stream LEN=3, words 0xfe010113, 0x00112e23, 0x00812c23, CHK=0xfe910313, byte_valid held 1 -> required response:
  - mem_write pulses at addr 0x0, 0x4, 0x8 with those words;
  - done=1, error=0, words_written=3, busy=0.
- Bad checksum: same stream with CHK=0x00000000 -> three writes still occur; error=1, done=0.
- Empty and overflow:
  - LEN=0, CHK=0 -> done=1, no mem_write.
  - LEN=0, CHK=1 -> error=1.
  - LEN=1025 with MEM_DEPTH=1024 -> error=1 after 4th LEN byte, zero writes, byte_ready=0.
- Backpressure/gaps:
  - random byte_valid gaps -> identical writes to the nominal case.
  - byte_valid=1 during WRITE -> byte_ready=0, and that byte is written correctly in the next word, not lost or duplicated.
- Reset mid-load: assert reset after 2nd word written plus 2 bytes of the 3rd -> outputs at reset values immediately; mem[0..1] retain data. Then start and a full nominal load -> done=1, words_written=3.
- Restart: start while busy ignored; start in DONE -> done clears next cycle, new load proceeds from BASE_ADDR.
